// File: rtl/datapath_rr_arbiter.sv
// Round-robin arbiter for a 4:1 datapath mux: registered one-hot grant and select,
// with a bounded hold time while other requesters wait, plus the muxed operand on w.
module datapath_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] w
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = '1;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       others;
  logic             at_limit;
  logic             release_now;
  logic [1:0]       win;
  logic [WIDTH-1:0] mux_out;

  // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    valid_d     = valid_q;
    hold_d      = hold_q;
    win         = 2'd0;
    others      = req & ~gnt_q;
    // Once the limit is reached, the next competing request takes over.
    at_limit    = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST);
    release_now = !req[sel_q] || (at_limit && (|others));
    case (state_q)
      IDLE: begin
        if (|req) begin
          win     = pick(req, ptr_q);
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d  = sel_q + 2'd1;
          hold_d = '0;
          if (|others) begin
            // The outgoing owner is masked out of this arbitration.
            win   = pick(others, sel_q + 2'd1);
            sel_d = win;
            gnt_d = 4'b0001 << win;
          end else begin
            state_d = IDLE;
            sel_d   = 2'd0;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    mux_out = data0;
      2'd1:    mux_out = data1;
      2'd2:    mux_out = data2;
      default: mux_out = data3;
    endcase
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign w     = valid_q ? mux_out : '0;

endmodule
